dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 (core load/store) and port 1 (DMA/debug loader).
- Each port uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin, with an optional bounded lock for bursts.
- Sits between the requesters and the data memory. The memory write port is clocked, and read data is registered, valid one cycle after the address is issued.

---
 rtl/dmem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between
// the core load/store port (0) and the DMA/debug loader port (1).
module dmem_arbiter #(
    parameter int ADDRW    = 12,
    parameter int DATAW    = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [1:0]         req_we,
    input  logic [1:0]         req_lock,
    input  logic [5:0]         req_funct3,
    input  logic [2*ADDRW-1:0] req_addr,
    input  logic [2*DATAW-1:0] req_wdata,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [DATAW-1:0]   rsp_rdata,
    output logic               mem_we,
    output logic [2:0]         mem_funct3,
    output logic [ADDRW-1:0]   mem_addr,
    output logic [DATAW-1:0]   mem_wdata,
    input  logic [DATAW-1:0]   mem_rdata
);

    localparam int CNTW = $clog2(MAX_LOCK + 1);
    localparam logic [CNTW-1:0] LOCK_MAX = CNTW'(MAX_LOCK);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic              owner_q, owner_d;
    logic              owner_we_q, owner_we_d;
    logic              lock_v_q, lock_v_d;
    logic              lock_p_q, lock_p_d;
    logic [CNTW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [DATAW-1:0]  hold_q, hold_d;

    logic              busy;
    logic              rsp_done;
    logic              can_issue;
    logic              lock_hit;
    logic              gnt_v;
    logic              gnt;
    logic              gnt_ok;
    logic              sel_we;
    logic              sel_lock;
    logic [2:0]        sel_funct3;
    logic [ADDRW-1:0]  sel_addr;
    logic [DATAW-1:0]  sel_wdata;

    // Decide whether a new access may start and which port wins it.
    always_comb begin
        busy      = (state_q != IDLE);
        rsp_done  = busy && rsp_ready[owner_q];
        can_issue = !busy || rsp_done;
        lock_hit  = lock_v_q && req_valid[lock_p_q]
                    && (lock_cnt_q < LOCK_MAX);
        gnt_v     = 1'b0;
        gnt       = 1'b0;
        if (can_issue) begin
            if (lock_hit) begin
                gnt_v = 1'b1;
                gnt   = lock_p_q;
            end else if (req_valid == 2'b11) begin
                gnt_v = 1'b1;
                gnt   = rr_q;
            end else if (req_valid != 2'b00) begin
                gnt_v = 1'b1;
                gnt   = req_valid[1];
            end
        end
        // Outputs stay quiet while reset is held, even with live requests.
        gnt_ok = gnt_v && rst;
    end

    // Select the winning port's request fields.
    always_comb begin
        sel_we     = gnt ? req_we[1] : req_we[0];
        sel_lock   = gnt ? req_lock[1] : req_lock[0];
        sel_funct3 = gnt ? req_funct3[5:3] : req_funct3[2:0];
        sel_addr   = gnt ? req_addr[2*ADDRW-1:ADDRW]
                         : req_addr[ADDRW-1:0];
        sel_wdata  = gnt ? req_wdata[2*DATAW-1:DATAW]
                         : req_wdata[DATAW-1:0];
    end

    // Drive the request handshake and the memory port.
    always_comb begin
        req_ready  = 2'b00;
        mem_we     = 1'b0;
        mem_funct3 = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (gnt_ok) begin
            req_ready[gnt] = 1'b1;
            mem_we         = sel_we;
            mem_funct3     = sel_funct3;
            mem_addr       = sel_addr;
            mem_wdata      = sel_wdata;
        end
    end

    // Present the response: live memory data first, held copy afterwards.
    always_comb begin
        rsp_valid = 2'b00;
        rsp_rdata = '0;
        unique case (state_q)
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                rsp_rdata = owner_we_q ? '0 : mem_rdata;
            end
            HOLD: begin
                rsp_valid[owner_q] = 1'b1;
                rsp_rdata = hold_q;
            end
            default: ;
        endcase
    end

    // Next-state, round-robin pointer and burst-lock bookkeeping.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        owner_we_d = owner_we_q;
        lock_v_d   = lock_v_q;
        lock_p_d   = lock_p_q;
        lock_cnt_d = lock_cnt_q;
        hold_d     = hold_q;
        if (gnt_v) begin
            state_d    = RESP;
            rr_d       = ~gnt;
            owner_d    = gnt;
            owner_we_d = sel_we;
            if (sel_lock) begin
                // An expired lock restarts counting as a fresh owner.
                if (lock_hit && (lock_p_q == gnt)) begin
                    lock_cnt_d = lock_cnt_q + CNT_ONE;
                end else begin
                    lock_v_d   = 1'b1;
                    lock_p_d   = gnt;
                    lock_cnt_d = CNT_ONE;
                end
            end else begin
                lock_v_d   = 1'b0;
                lock_cnt_d = '0;
            end
        end else begin
            unique case (state_q)
                IDLE: ;
                RESP: begin
                    if (rsp_ready[owner_q]) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        hold_d  = owner_we_q ? '0 : mem_rdata;
                    end
                end
                HOLD: begin
                    if (rsp_ready[owner_q]) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            owner_q    <= 1'b0;
            owner_we_q <= 1'b0;
            lock_v_q   <= 1'b0;
            lock_p_q   <= 1'b0;
            lock_cnt_q <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            owner_we_q <= owner_we_d;
            lock_v_q   <= lock_v_d;
            lock_p_q   <= lock_p_d;
            lock_cnt_q <= lock_cnt_d;
            hold_q     <= hold_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a request-level reference model
// predicts grants and responses; a monitor checks responses in order.
module tb_dmem_arbiter;

    localparam int ADDRW    = 12;
    localparam int DATAW    = 32;
    localparam int MAX_LOCK = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [1:0]        req_lock;
    logic [5:0]        req_funct3;
    logic [23:0]       req_addr;
    logic [63:0]       req_wdata;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              mem_we;
    logic [2:0]        mem_funct3;
    logic [11:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [31:0] mem    [0:1023];
    logic [31:0] refmem [0:1023];
    logic        corrupt;

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t q[$];

    bit   m_rr   = 1'b0;
    bit   m_lv   = 1'b0;
    bit   m_lp   = 1'b0;
    int   m_cnt  = 0;
    bit   m_busy = 1'b0;
    bit   m_own  = 1'b0;

    dmem_arbiter #(
        .ADDRW(ADDRW), .DATAW(DATAW), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_lock(req_lock),
        .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .mem_we(mem_we), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: clocked write, registered read one cycle after issue.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
        mem_rdata <= corrupt ? 32'hFFFF_FFFF : mem[mem_addr[11:2]];
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model: grant rules applied to the live inputs.
    initial begin : model
        bit          can, gv, g, we;
        int          gi;
        logic [1:0]  exp_rdy;
        logic [11:0] a;
        logic [31:0] wd;
        logic [2:0]  f3;
        exp_t        e;
        forever begin
            @(negedge clk or negedge rst);
            if (!rst) begin
                m_rr = 0; m_lv = 0; m_lp = 0;
                m_cnt = 0; m_busy = 0; m_own = 0;
            end else begin
                can = !m_busy || rsp_ready[m_own];
                gv = 0;
                g  = 0;
                if (can) begin
                    if (m_lv && req_valid[m_lp] && m_cnt < MAX_LOCK) begin
                        gv = 1; g = m_lp;
                    end else if (req_valid == 2'b11) begin
                        gv = 1; g = m_rr;
                    end else if (req_valid != 2'b00) begin
                        gv = 1; g = req_valid[1];
                    end
                end
                exp_rdy = gv ? (2'b01 << g) : 2'b00;
                chk("req_ready", {62'd0, req_ready}, {62'd0, exp_rdy});
                if (gv) begin
                    gi = int'(g);
                    we = req_we[gi];
                    a  = req_addr[gi*12 +: 12];
                    wd = req_wdata[gi*32 +: 32];
                    f3 = req_funct3[gi*3 +: 3];
                    chk("mem_we", {63'd0, mem_we}, {63'd0, we});
                    chk("mem_addr", {52'd0, mem_addr}, {52'd0, a});
                    chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, wd});
                    chk("mem_funct3", {61'd0, mem_funct3}, {61'd0, f3});
                    e.port = g;
                    e.data = we ? 32'd0 : refmem[a[11:2]];
                    e.cyc  = cyc;
                    q.push_back(e);
                    if (we) refmem[a[11:2]] = wd;
                    m_rr = !g;
                    if (req_lock[gi]) begin
                        if (m_lv && m_lp == g && m_cnt < MAX_LOCK) begin
                            m_cnt++;
                        end else begin
                            m_lv = 1; m_lp = g; m_cnt = 1;
                        end
                    end else begin
                        m_lv = 0; m_cnt = 0;
                    end
                    m_busy = 1;
                    m_own  = g;
                end else begin
                    chk("mem_we_idle", {63'd0, mem_we}, 64'd0);
                    if (m_busy && rsp_ready[m_own]) m_busy = 0;
                end
            end
        end
    end

    // Monitor: responses appear in issue order on the expected port.
    initial begin : monitor
        logic [1:0] ev;
        forever begin
            @(negedge clk or negedge rst);
            if (!rst) begin
                q.delete();
            end else if (q.size() > 0 && q[0].cyc < cyc) begin
                ev = 2'b01 << q[0].port;
                chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, ev});
                chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, q[0].data});
                if (rsp_ready[q[0].port]) void'(q.pop_front());
            end else begin
                chk("rsp_quiet", {62'd0, rsp_valid}, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input bit v, input bit we,
                            input bit lk, input logic [2:0] f3,
                            input logic [11:0] a, input logic [31:0] wd);
        req_valid[p]          = v;
        req_we[p]             = we;
        req_lock[p]           = lk;
        req_funct3[p*3 +: 3]  = f3;
        req_addr[p*12 +: 12]  = a;
        req_wdata[p*32 +: 32] = wd;
    endtask

    task automatic idle_all();
        set_port(0, 0, 0, 0, 3'b000, 12'h000, 32'h0);
        set_port(1, 0, 0, 0, 3'b000, 12'h000, 32'h0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, {62'd0, req_ready}, 64'd0);
        chk({tag, "_rsp_valid"}, {62'd0, rsp_valid}, 64'd0);
        chk({tag, "_rsp_rdata"}, {32'd0, rsp_rdata}, 64'd0);
        chk({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
        chk({tag, "_mem_addr"}, {52'd0, mem_addr}, 64'd0);
        chk({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
        chk({tag, "_mem_funct3"}, {61'd0, mem_funct3}, 64'd0);
    endtask

    // Pulse reset mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_zero("rst");
        #1;
        rst = 1'b1;
    endtask

    task automatic drain();
        idle_all();
        rsp_ready = 2'b11;
        tick();
        tick();
    endtask

    task automatic rand_port(input int p);
        set_port(p, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 3) == 0, 3'($urandom),
                 {5'd0, 5'($urandom_range(0, 31)), 2'b00}, $urandom);
    endtask

    initial begin : stim
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = $urandom;
            refmem[i] = mem[i];
        end
        corrupt   = 1'b0;
        rsp_ready = 2'b11;
        idle_all();
        set_port(0, 1, 1, 1, 3'b010, 12'h010, 32'h1);
        set_port(1, 1, 0, 0, 3'b010, 12'h014, 32'h2);
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 check_zero("reset");
        idle_all();
        #1 rst = 1'b1;
        tick();

        // Single port-0 load of a known word.
        mem[4]    = 32'hDEAD_BEEF;
        refmem[4] = 32'hDEAD_BEEF;
        set_port(0, 1, 0, 0, 3'b010, 12'h010, 32'h0);
        tick();
        idle_all();
        tick();
        tick();

        // Both ports streaming loads: strict alternation from port 0.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_port(0, 1, 0, 0, 3'b010, {5'd0, 5'(i), 2'b00}, 32'h0);
            set_port(1, 1, 0, 0, 3'b010, {5'd1, 5'(i), 2'b00}, 32'h0);
            tick();
        end
        drain();

        // Port-1 store with a stalled response while port 0 waits.
        set_port(1, 1, 1, 0, 3'b010, 12'h020, 32'h1234_5678);
        rsp_ready = 2'b01;
        tick();
        set_port(1, 0, 0, 0, 3'b000, 12'h000, 32'h0);
        set_port(0, 1, 0, 0, 3'b010, 12'h020, 32'h0);
        tick();
        tick();
        tick();
        rsp_ready = 2'b11;
        tick();
        drain();

        // Port 0 holds a burst lock against a busy port 1.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_port(0, 1, 0, 1, 3'b010, {5'd2, 5'(i), 2'b00}, 32'h0);
            set_port(1, 1, 0, 0, 3'b010, {5'd3, 5'(i), 2'b00}, 32'h0);
            tick();
        end
        drain();

        // Stalled load keeps the captured word while memory output moves.
        mem[16]    = 32'hA5A5_A5A5;
        refmem[16] = 32'hA5A5_A5A5;
        rsp_ready  = 2'b00;
        set_port(0, 1, 0, 0, 3'b010, 12'h040, 32'h0);
        tick();
        idle_all();
        corrupt = 1'b1;
        tick();
        tick();
        tick();
        rsp_ready = 2'b11;
        corrupt   = 1'b0;
        tick();
        drain();

        // Reset while a port-1 response is held; port 0 must win after.
        rsp_ready = 2'b00;
        set_port(1, 1, 0, 0, 3'b010, 12'h030, 32'h0);
        tick();
        idle_all();
        tick();
        set_port(0, 1, 0, 0, 3'b010, 12'h010, 32'h0);
        set_port(1, 1, 0, 0, 3'b010, 12'h014, 32'h0);
        rsp_ready = 2'b11;
        do_reset();
        tick();
        drain();

        // Random traffic with random response back-pressure.
        for (int i = 0; i < 3000; i++) begin
            rand_port(0);
            rand_port(1);
            rsp_ready[0] = $urandom_range(0, 3) != 0;
            rsp_ready[1] = $urandom_range(0, 3) != 0;
            tick();
        end
        drain();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
